// File: rtl/lsu_bus.sv
// rtl/lsu_bus.sv - load/store unit bus adapter: lane steering, load extension, bus timeout
// Three-state access engine (IDLE -> BUSY -> DONE) between the core LSU and a req/ack memory bus.
module lsu_bus #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  load_code,
   input  logic [1:0]  store_code,
   input  logic [31:0] addr,
   input  logic [31:0] data_store,
   output logic [31:0] data_load,
   output logic        ld_valid,
   output logic        stall,
   output logic        misalign,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state, state_next;
   logic [CW-1:0] wait_cnt;
   logic [2:0]    code_q;
   logic [1:0]    lane_q;
   logic          is_load_q;

   logic          load_valid;
   logic          store_valid;
   logic          req;
   logic          mis;
   logic          timed_out;
   logic [3:0]    wstrb_new;
   logic [31:0]   wdata_new;

   function automatic logic [31:0] extend(input logic [2:0] code, input logic [1:0] lane,
                                          input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = lane[1] ? rdata[31:16] : rdata[15:0];
      case (code)
         3'b000:  extend = {{24{b[7]}}, b};
         3'b100:  extend = {24'b0, b};
         3'b001:  extend = {{16{h[15]}}, h};
         3'b101:  extend = {16'b0, h};
         default: extend = rdata;
      endcase
   endfunction

   // Request decode: a valid load takes priority over a store in the same cycle.
   always_comb begin
      load_valid = 1'b0;
      case (load_code)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_valid = 1'b1;
         default: load_valid = 1'b0;
      endcase
      store_valid = (store_code != 2'b11);
      req         = load_valid || store_valid;

      mis = 1'b0;
      if (load_valid) begin
         case (load_code)
            3'b001, 3'b101: mis = addr[0];
            3'b010:         mis = |addr[1:0];
            default:        mis = 1'b0;
         endcase
      end else begin
         case (store_code)
            2'b01:   mis = addr[0];
            2'b10:   mis = |addr[1:0];
            default: mis = 1'b0;
         endcase
      end

      wstrb_new = 4'b0000;
      wdata_new = 32'b0;
      if (!load_valid) begin
         case (store_code)
            2'b00: begin
               wstrb_new = 4'b0001 << addr[1:0];
               wdata_new = {4{data_store[7:0]}};
            end
            2'b01: begin
               wstrb_new = 4'b0011 << addr[1:0];
               wdata_new = {2{data_store[15:0]}};
            end
            2'b10: begin
               wstrb_new = 4'b1111;
               wdata_new = data_store;
            end
            default: begin
               wstrb_new = 4'b0000;
               wdata_new = 32'b0;
            end
         endcase
      end
   end

   assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));

   always_comb begin
      state_next = state;
      stall      = 1'b0;
      misalign   = 1'b0;
      mem_req    = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (mis) begin
                  misalign = 1'b1;
               end else begin
                  stall      = 1'b1;
                  state_next = BUSY;
               end
            end
         end
         BUSY: begin
            mem_req = 1'b1;
            stall   = 1'b1;
            if (mem_ack || timed_out) state_next = DONE;
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         code_q    <= 3'b0;
         lane_q    <= 2'b0;
         is_load_q <= 1'b0;
         mem_addr  <= 32'b0;
         mem_we    <= 1'b0;
         mem_wstrb <= 4'b0;
         mem_wdata <= 32'b0;
         data_load <= 32'b0;
         ld_valid  <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (req && !mis) begin
                  wait_cnt  <= '0;
                  code_q    <= load_code;
                  lane_q    <= addr[1:0];
                  is_load_q <= load_valid;
                  mem_addr  <= {addr[31:2], 2'b00};
                  mem_we    <= !load_valid;
                  mem_wstrb <= wstrb_new;
                  mem_wdata <= wdata_new;
               end
            end
            BUSY: begin
               // Ack beats a simultaneous timeout.
               if (mem_ack) begin
                  if (is_load_q) data_load <= extend(code_q, lane_q, mem_rdata);
                  ld_valid <= is_load_q;
               end else if (timed_out) begin
                  data_load <= 32'b0;
                  bus_err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: begin
               ld_valid <= 1'b0;
               bus_err  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus.sv
// tb/tb_lsu_bus.sv - self-checking bench for lsu_bus against a behavioural access model
module tb_lsu_bus;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  load_code;
   logic [1:0]  store_code;
   logic [31:0] addr;
   logic [31:0] data_store;
   logic [31:0] data_load;
   logic        ld_valid;
   logic        stall;
   logic        misalign;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   lsu_bus #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .load_code(load_code), .store_code(store_code),
      .addr(addr), .data_store(data_store), .data_load(data_load), .ld_valid(ld_valid),
      .stall(stall), .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic bit m_is_load(input logic [2:0] ld);
      return (ld == 3'd0 || ld == 3'd1 || ld == 3'd2 || ld == 3'd4 || ld == 3'd5);
   endfunction

   function automatic bit m_mis(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a);
      int size;
      if (m_is_load(ld)) size = (ld == 3'd2) ? 4 : ((ld == 3'd1 || ld == 3'd5) ? 2 : 1);
      else               size = (st == 2'd2) ? 4 : ((st == 2'd1) ? 2 : 1);
      return (a % size) != 0;
   endfunction

   function automatic logic [3:0] m_wstrb(input logic [1:0] st, input logic [31:0] a);
      int lane = a % 4;
      if (st == 2'd0) return 4'(1 << lane);
      if (st == 2'd1) return 4'(3 << lane);
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] st, input logic [31:0] d);
      if (st == 2'd0) return (d % 256) * 32'h0101_0101;
      if (st == 2'd1) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] ld, input logic [31:0] a,
                                          input logic [31:0] rd);
      longint unsigned v;
      int lane = a % 4;
      if (ld == 3'd0 || ld == 3'd4) begin
         v = (rd >> (8 * lane)) % 256;
         if (ld == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (ld == 3'd1 || ld == 3'd5) begin
         v = (rd >> (16 * (lane / 2))) % 65536;
         if (ld == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v[31:0];
   endfunction

   task automatic set_idle();
      load_code  = 3'b111;
      store_code = 2'b11;
      addr       = $urandom;
      data_store = $urandom;
   endtask

   // One complete access; ack_k is the BUSY cycle (1-based) that carries mem_ack, >TIMEOUT or 0 = none.
   task automatic do_access(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                            input logic [31:0] d, input int ack_k, input logic [31:0] rd,
                            output int stalls);
      bit          is_ld = m_is_load(ld);
      bit          emis  = m_mis(ld, st, a);
      bit          acked = 1'b0;
      logic [31:0] eload = m_load(ld, a, rd);
      stalls = 0;
      @(posedge clk); #1;
      load_code = ld; store_code = st; addr = a; data_store = d;
      @(negedge clk);
      n_checks++;
      if (misalign !== emis) begin n_fail++; $display("FAIL idle_misalign addr=%h got=%b exp=%b", a, misalign, emis); end
      n_checks++;
      if (stall !== !emis) begin n_fail++; $display("FAIL idle_stall addr=%h got=%b exp=%b", a, stall, !emis); end
      n_checks++;
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got=%b exp=0", mem_req); end
      if (stall === 1'b1) stalls++;
      if (emis) begin
         @(posedge clk); #1; set_idle();
         @(negedge clk);
         n_checks++;
         if (mem_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL mis_no_access req=%b stall=%b exp 0/0", mem_req, stall);
         end
         return;
      end
      @(posedge clk); #1; set_idle();
      for (int k = 1; k <= TIMEOUT && !acked; k++) begin
         @(negedge clk);
         n_checks++;
         if (mem_req !== 1'b1 || stall !== 1'b1) begin
            n_fail++; $display("FAIL busy_req k=%0d req=%b stall=%b exp 1/1", k, mem_req, stall);
         end
         n_checks++;
         if (mem_addr !== {a[31:2], 2'b00} || mem_we !== !is_ld) begin
            n_fail++; $display("FAIL busy_addr_we k=%0d addr=%h we=%b exp %h/%b", k, mem_addr, mem_we, {a[31:2], 2'b00}, !is_ld);
         end
         if (!is_ld) begin
            n_checks++;
            if (mem_wstrb !== m_wstrb(st, a) || mem_wdata !== m_wdata(st, d)) begin
               n_fail++; $display("FAIL busy_wlanes k=%0d wstrb=%b wdata=%h exp %b/%h", k, mem_wstrb, mem_wdata, m_wstrb(st, a), m_wdata(st, d));
            end
         end
         if (stall === 1'b1) stalls++;
         if (k == ack_k) begin mem_ack = 1'b1; mem_rdata = rd; acked = 1'b1; end
         else begin mem_ack = 1'b0; mem_rdata = $urandom; end
         @(posedge clk); #1; mem_ack = 1'b0;
      end
      // Stray ack during DONE must be ignored.
      mem_ack = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0) begin
         n_fail++; $display("FAIL done_idle_bus stall=%b req=%b exp 0/0", stall, mem_req);
      end
      n_checks++;
      if (ld_valid !== (is_ld && acked)) begin n_fail++; $display("FAIL done_ld_valid got=%b exp=%b", ld_valid, is_ld && acked); end
      n_checks++;
      if (bus_err !== !acked) begin n_fail++; $display("FAIL done_bus_err got=%b exp=%b", bus_err, !acked); end
      if (is_ld && acked) begin
         n_checks++;
         if (data_load !== eload) begin n_fail++; $display("FAIL done_data_load addr=%h got=%h exp=%h", a, data_load, eload); end
      end
      if (!acked) begin
         n_checks++;
         if (data_load !== 32'h0) begin n_fail++; $display("FAIL timeout_data_load got=%h exp=0", data_load); end
      end
      @(posedge clk); #1; mem_ack = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b0 || ld_valid !== 1'b0 || bus_err !== 1'b0) begin
         n_fail++; $display("FAIL back_idle req=%b ldv=%b err=%b exp 0/0/0", mem_req, ld_valid, bus_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; set_idle(); mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'b0) begin
         n_fail++; $display("FAIL reset_bus req=%b we=%b wstrb=%b exp 0", mem_req, mem_we, mem_wstrb);
      end
      n_checks++;
      if (ld_valid !== 1'b0 || bus_err !== 1'b0 || data_load !== 32'h0) begin
         n_fail++; $display("FAIL reset_result ldv=%b err=%b data=%h exp 0", ld_valid, bus_err, data_load);
      end
      n_checks++;
      if (stall !== 1'b0 || misalign !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle stall=%b mis=%b exp 0/0", stall, misalign);
      end
   endtask

   task automatic test_lb_extension();
      int s;
      do_access(3'b000, 2'b11, 32'h103, 32'h0, 3, 32'h80FF_0000, s);
      n_checks++;
      if (s != 4) begin n_fail++; $display("FAIL lb_stall_cycles got=%0d exp=4", s); end
      do_access(3'b100, 2'b11, 32'h103, 32'h0, 3, 32'h80FF_0000, s);
      n_checks++;
      if (s != 4) begin n_fail++; $display("FAIL lbu_stall_cycles got=%0d exp=4", s); end
   endtask

   task automatic test_store_half();
      int s;
      do_access(3'b111, 2'b01, 32'h202, 32'h1234_ABCD, 2, 32'h0, s);
   endtask

   task automatic test_misalign();
      int s;
      do_access(3'b010, 2'b11, 32'h6, 32'h0, 1, 32'h0, s);
      do_access(3'b111, 2'b01, 32'h11, 32'h0, 1, 32'h0, s);
      do_access(3'b101, 2'b11, 32'h23, 32'h0, 1, 32'h0, s);
   endtask

   task automatic test_timeout();
      int s;
      do_access(3'b010, 2'b11, 32'h40, 32'h0, 0, 32'h0, s);
      n_checks++;
      if (s != TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_stall_cycles got=%0d exp=%0d", s, TIMEOUT + 1); end
      do_access(3'b001, 2'b11, 32'h42, 32'h0, TIMEOUT, 32'h0000_9876, s);
   endtask

   task automatic test_reset_busy();
      int s;
      @(posedge clk); #1;
      load_code = 3'b010; store_code = 2'b11; addr = 32'h80;
      @(posedge clk); #1; set_idle();
      @(posedge clk); #1;
      rst = 1'b1; mem_ack = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (mem_req !== 1'b0 || ld_valid !== 1'b0 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_abandon i=%0d req=%b ldv=%b err=%b exp 0/0/0", i, mem_req, ld_valid, bus_err);
         end
      end
      do_access(3'b010, 2'b11, 32'h84, 32'h0, 2, 32'hCAFE_F00D, s);
   endtask

   task automatic test_load_store_priority();
      int s;
      do_access(3'b010, 2'b10, 32'h300, 32'hDEAD_BEEF, 1, 32'h1357_9BDF, s);
   endtask

   task automatic test_random();
      logic [2:0] ld;
      logic [1:0] st;
      int s;
      logic [2:0] ld_tab [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd7};
      for (int i = 0; i < 40; i++) begin
         ld = ld_tab[$urandom_range(0, 5)];
         st = (ld == 3'd7) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
         do_access(ld, st, $urandom, $urandom, $urandom_range(1, TIMEOUT + 2), $urandom, s);
      end
   endtask

   initial begin
      test_reset();
      test_lb_extension();
      test_store_half();
      test_misalign();
      test_timeout();
      test_reset_busy();
      test_load_store_priority();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
